airlock_sequencer: RTL and testbench

- Central interlock controller for the two-port chamber.
- Accepts one-clock request pulses: port open/close, fill-and-pressurize, evacuate. These come from the debounced/synchronised key and switch front end.
- Sequences the chamber through its states, times the pressurize and evacuate phases, and rejects any request that would violate the interlock.
- Its outputs drive the port-state LEDs and the HEX status digit; it replaces the free-running per-port toggle counters.

---
 rtl/airlock_sequencer.sv | 149 ++++++++++++++
 tb/tb_airlock_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/airlock_sequencer.sv
// Interlock sequencer for the two-port airlock chamber.
// Turns one-cycle request pulses into chamber state, pump timing and port drive.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   open_outer      request pulse: open the outer port
//   close_outer     request pulse: close the outer port
//   open_inner      request pulse: open the inner port
//   close_inner     request pulse: close the inner port
//   start_press     request pulse: fill and pressurize the chamber
//   start_evac      request pulse: evacuate the chamber
//   outer_open      outer port open
//   inner_open      inner port open
//   pressurized     chamber at inner pressure
//   pumping         high while pressurizing or evacuating
//   remaining       cycles left in the current pump phase, 0 otherwise
//   state           encoded chamber state for the HEX digit
//   reject          one-cycle pulse when a request is refused

module airlock_sequencer #(
   parameter int unsigned PRESS_CYCLES = 8,
   parameter int unsigned EVAC_CYCLES  = 6,
   parameter int unsigned TW           = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          open_outer,
   input  logic          close_outer,
   input  logic          open_inner,
   input  logic          close_inner,
   input  logic          start_press,
   input  logic          start_evac,
   output logic          outer_open,
   output logic          inner_open,
   output logic          pressurized,
   output logic          pumping,
   output logic [TW-1:0] remaining,
   output logic [2:0]    state,
   output logic          reject
);

   localparam logic [2:0] EVAC_IDLE    = 3'd0;
   localparam logic [2:0] OUTER_OPEN   = 3'd1;
   localparam logic [2:0] PRESSURIZING = 3'd2;
   localparam logic [2:0] PRESS_IDLE   = 3'd3;
   localparam logic [2:0] INNER_OPEN   = 3'd4;
   localparam logic [2:0] EVACUATING   = 3'd5;

   localparam logic [TW-1:0] PRESS_LOAD = TW'(PRESS_CYCLES);
   localparam logic [TW-1:0] EVAC_LOAD  = TW'(EVAC_CYCLES);
   localparam logic [TW-1:0] ONE        = TW'(1);

   // Bit 0 is the highest-priority request.
   logic [5:0] req;
   logic [5:0] sel;
   logic       multi;

   logic [2:0]    state_nx;
   logic [TW-1:0] rem_nx;
   logic          refuse;

   assign req = {start_evac, start_press, open_inner,
                 open_outer, close_inner, close_outer};

   // Isolate the lowest set bit: the request that wins arbitration.
   assign sel   = req & ~(req - 6'd1);
   assign multi = (req & (req - 6'd1)) != 6'd0;

   always_comb begin
      state_nx = state;
      rem_nx   = remaining;
      refuse   = 1'b0;
      if (state == PRESSURIZING || state == EVACUATING) begin
         // Pump phases cannot be interrupted; every request is refused.
         refuse = |req;
         if (remaining <= ONE) begin
            rem_nx   = '0;
            state_nx = (state == PRESSURIZING) ? PRESS_IDLE : EVAC_IDLE;
         end else begin
            rem_nx = remaining - ONE;
         end
      end else if (state > EVACUATING) begin
         // Unused encodings fall back to the safe evacuated state.
         state_nx = EVAC_IDLE;
         rem_nx   = '0;
      end else begin
         unique case (1'b1)
            sel[0]: begin
               if (state == OUTER_OPEN) state_nx = EVAC_IDLE;
               else refuse = 1'b1;
            end
            sel[1]: begin
               if (state == INNER_OPEN) state_nx = PRESS_IDLE;
               else refuse = 1'b1;
            end
            sel[2]: begin
               if (state == EVAC_IDLE) state_nx = OUTER_OPEN;
               else refuse = 1'b1;
            end
            sel[3]: begin
               if (state == PRESS_IDLE) state_nx = INNER_OPEN;
               else refuse = 1'b1;
            end
            sel[4]: begin
               if (state == EVAC_IDLE) begin
                  state_nx = PRESSURIZING;
                  rem_nx   = PRESS_LOAD;
               end else begin
                  refuse = 1'b1;
               end
            end
            sel[5]: begin
               if (state == PRESS_IDLE) begin
                  state_nx = EVACUATING;
                  rem_nx   = EVAC_LOAD;
               end else begin
                  refuse = 1'b1;
               end
            end
            default: ;
         endcase
         if (multi) refuse = 1'b1;
      end
   end

   // Outputs are decoded from the next state so they line up with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= EVAC_IDLE;
         remaining   <= '0;
         outer_open  <= 1'b0;
         inner_open  <= 1'b0;
         pressurized <= 1'b0;
         pumping     <= 1'b0;
         reject      <= 1'b0;
      end else begin
         state       <= state_nx;
         remaining   <= rem_nx;
         outer_open  <= state_nx == OUTER_OPEN;
         inner_open  <= state_nx == INNER_OPEN;
         pressurized <= state_nx == PRESS_IDLE ||
                        state_nx == INNER_OPEN;
         pumping     <= state_nx == PRESSURIZING ||
                        state_nx == EVACUATING;
         reject      <= refuse;
      end
   end

endmodule

// File: tb/tb_airlock_sequencer.sv
// Bench for airlock_sequencer: directed scenarios, async reset and random pulses.
// A chamber model (ports, pressure, pump countdown) supplies every expectation.

module tb_airlock_sequencer;

   localparam int P  = 4;
   localparam int E  = 3;
   localparam int TW = 8;

   localparam logic [5:0] CO = 6'b000001;
   localparam logic [5:0] CI = 6'b000010;
   localparam logic [5:0] OO = 6'b000100;
   localparam logic [5:0] OI = 6'b001000;
   localparam logic [5:0] SP = 6'b010000;
   localparam logic [5:0] SE = 6'b100000;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          open_outer = 1'b0, close_outer = 1'b0;
   logic          open_inner = 1'b0, close_inner = 1'b0;
   logic          start_press = 1'b0, start_evac = 1'b0;
   logic          outer_open, inner_open, pressurized, pumping, reject;
   logic [TW-1:0] remaining;
   logic [2:0]    state;

   int total = 0;
   int passed = 0;

   // Chamber model: physical facts rather than a state register.
   bit m_outer, m_inner, m_press, m_pump_press, m_rej;
   int m_left;

   airlock_sequencer #(
      .PRESS_CYCLES(P), .EVAC_CYCLES(E), .TW(TW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .open_outer(open_outer), .close_outer(close_outer),
      .open_inner(open_inner), .close_inner(close_inner),
      .start_press(start_press), .start_evac(start_evac),
      .outer_open(outer_open), .inner_open(inner_open),
      .pressurized(pressurized), .pumping(pumping),
      .remaining(remaining), .state(state), .reject(reject)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   function automatic int m_state();
      if (m_left > 0) return m_pump_press ? 2 : 5;
      if (m_outer) return 1;
      if (m_inner) return 4;
      return m_press ? 3 : 0;
   endfunction

   task automatic model_reset();
      m_outer = 0; m_inner = 0; m_press = 0;
      m_pump_press = 0; m_left = 0; m_rej = 0;
   endtask

   task automatic model_step(input logic [5:0] r);
      int n;
      int pick;
      bit idle;
      n = $countones(r);
      m_rej = 0;
      if (m_left > 0) begin
         m_rej = n > 0;
         m_left--;
         if (m_left == 0 && m_pump_press) m_press = 1;
      end else if (n > 0) begin
         pick = 0;
         while (!r[pick]) pick++;
         m_rej = n > 1;
         idle = !m_outer && !m_inner;
         case (pick)
            0: if (m_outer) m_outer = 0; else m_rej = 1;
            1: if (m_inner) m_inner = 0; else m_rej = 1;
            2: if (idle && !m_press) m_outer = 1; else m_rej = 1;
            3: if (idle && m_press) m_inner = 1; else m_rej = 1;
            4: if (idle && !m_press) begin
                  m_left = P; m_pump_press = 1;
               end else m_rej = 1;
            default: if (idle && m_press) begin
                  m_press = 0; m_left = E; m_pump_press = 0;
               end else m_rej = 1;
         endcase
      end
   endtask

   task automatic check_model();
      chk("state", 32'(state), 32'(m_state()));
      chk("outer_open", 32'(outer_open), 32'(m_outer));
      chk("inner_open", 32'(inner_open), 32'(m_inner));
      chk("pressurized", 32'(pressurized), 32'(m_press));
      chk("pumping", 32'(pumping), 32'(m_left > 0));
      chk("remaining", 32'(remaining), 32'(m_left));
      chk("reject", 32'(reject), 32'(m_rej));
   endtask

   task automatic drive(input logic [5:0] r);
      close_outer = r[0]; close_inner = r[1];
      open_outer  = r[2]; open_inner  = r[3];
      start_press = r[4]; start_evac  = r[5];
   endtask

   // Called at a negedge; one request cycle, checked at the next negedge.
   task automatic step(input logic [5:0] r);
      drive(r);
      @(posedge clk);
      model_step(r);
      #1 drive(6'd0);
      @(negedge clk);
      check_model();
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) step(6'd0);
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_model();
      chk("reset_state", 32'(state), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Pressurize and watch the countdown.
      step(SP);
      chk("press_pumping", 32'(pumping), 32'd1);
      chk("press_rem4", 32'(remaining), 32'd4);
      step(0); chk("press_rem3", 32'(remaining), 32'd3);
      step(0); chk("press_rem2", 32'(remaining), 32'd2);
      step(0); chk("press_rem1", 32'(remaining), 32'd1);
      step(0);
      chk("press_done_state", 32'(state), 32'd3);
      chk("press_done_p", 32'(pressurized), 32'd1);
      chk("press_done_rem", 32'(remaining), 32'd0);
      step(SE);
      idle_n(E);
      chk("back_evac_idle", 32'(state), 32'd0);

      // Outer port and a refused inner open.
      step(OO); chk("oo_open", 32'(outer_open), 32'd1);
      step(OI);
      chk("oi_reject", 32'(reject), 32'd1);
      chk("oi_inner", 32'(inner_open), 32'd0);
      step(0); chk("reject_one_cycle", 32'(reject), 32'd0);
      step(CO); chk("co_state", 32'(state), 32'd0);

      // Full cycle.
      step(SP); chk("full_s2", 32'(state), 32'd2);
      idle_n(P);
      chk("full_s3", 32'(state), 32'd3);
      step(OI); chk("full_s4", 32'(state), 32'd4);
      step(CI); chk("full_s3b", 32'(state), 32'd3);
      step(SE);
      chk("full_s5", 32'(state), 32'd5);
      chk("evac_p_drop", 32'(pressurized), 32'd0);
      idle_n(E - 1);
      chk("evac_held", 32'(state), 32'd5);
      step(0); chk("full_s0", 32'(state), 32'd0);

      // Requests during a pump phase are refused without disturbing it.
      step(SP);
      step(SE);
      chk("pump_rej_se", 32'(reject), 32'd1);
      chk("pump_rem_se", 32'(remaining), 32'd3);
      step(OO);
      chk("pump_rej_oo", 32'(reject), 32'd1);
      chk("pump_rem_oo", 32'(remaining), 32'd2);
      idle_n(2);
      chk("pump_end", 32'(state), 32'd3);
      step(SE);
      idle_n(E);

      // Simultaneous requests.
      step(OO | SP);
      chk("multi_s1", 32'(state), 32'd1);
      chk("multi_rej1", 32'(reject), 32'd1);
      step(CO | SP);
      chk("multi_s0", 32'(state), 32'd0);
      chk("multi_rej0", 32'(reject), 32'd1);

      // Asynchronous reset mid-evacuation.
      step(SP);
      idle_n(P);
      step(SE);
      step(0);
      chk("pre_rst_rem", 32'(remaining), 32'd2);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_model();
      @(negedge clk);
      rst_n = 1'b1;
      check_model();

      // Random pulses with interlock invariants.
      for (int i = 0; i < 10000; i++) begin
         logic [5:0] r;
         for (int b = 0; b < 6; b++)
            r[b] = ($urandom_range(0, 5) == 0);
         step(r);
         chk("inv_both_open", 32'(outer_open & inner_open), 32'd0);
         chk("inv_outer_p", 32'(outer_open & pressurized), 32'd0);
         chk("inv_inner_p", 32'(inner_open & ~pressurized), 32'd0);
         chk("inv_pump_ports",
             32'(pumping & (outer_open | inner_open)), 32'd0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
